// File: rtl/avr_serial_tx.sv
// Serial transmitter toward the AVR: 8N1 frames gated by the AVR's ready/block handshake.
// Define AVR_SERIAL_TX_PARITY_EN to insert an even-parity bit between bit 7 and stop (8E1).
module avr_serial_tx #(
  parameter int CLK_PER_BIT = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ready,
  input  logic       block,
  input  logic [7:0] data,
  input  logic       new_data,
  output logic       tx,
  output logic       busy
);

  localparam int CTR_W = $clog2(CLK_PER_BIT);
  localparam logic [CTR_W-1:0] CTR_MAX = CTR_W'(CLK_PER_BIT - 1);
  localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef AVR_SERIAL_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction

  state_t           state_q, state_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       data_q, data_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;
  logic             block_q, block_d;
  logic             bit_end_s;
  logic             accept_s;

  // Next-state, bit timer, bit index and the tx level of the upcoming cycle.
  always_comb begin
    state_d   = state_q;
    ctr_d     = ctr_q;
    bit_d     = bit_q;
    data_d    = data_q;
    tx_d      = 1'b1;
    ready_d   = ready;
    block_d   = block;
    bit_end_s = (ctr_q == CTR_MAX);
    accept_s  = (state_q == IDLE) && new_data && ready_q && !block_q;

    if (state_q == IDLE) begin
      ctr_d = '0;
    end else if (bit_end_s) begin
      ctr_d = '0;
    end else begin
      ctr_d = ctr_q + CTR_ONE;
    end

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = START;
          data_d  = data;
          bit_d   = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_d = DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          if (bit_q == 3'd7) begin
            bit_d = 3'd0;
`ifdef AVR_SERIAL_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
`ifdef AVR_SERIAL_TX_PARITY_EN
      PARITY: begin
        if (bit_end_s) begin
          state_d = STOP;
        end else begin
          state_d = PARITY;
        end
      end
`endif
      STOP: begin
        if (bit_end_s) begin
          state_d = IDLE;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
        bit_d   = 3'd0;
      end
    endcase

    // tx is registered, so it is derived from the state being entered.
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[bit_d];
`ifdef AVR_SERIAL_TX_PARITY_EN
      PARITY:  tx_d = even_parity(data_d);
`endif
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  // State and input-synchroniser registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ctr_q   <= '0;
      bit_q   <= 3'd0;
      data_q  <= 8'h00;
      tx_q    <= 1'b1;
      ready_q <= 1'b0;
      block_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      block_q <= block_d;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE) || block_q || !ready_q;

endmodule
